// File: rtl/rv32_ctrl_pkg.sv
// Shared encodings for the RV32 multicycle control sequencer: opcodes, ALU codes,
// FSM states, instruction classes and datapath mux selects.
package rv32_ctrl_pkg;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_IALU   = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_SLL  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_XOR  = 4'd6;
    localparam logic [3:0] ALU_SRL  = 4'd7;
    localparam logic [3:0] ALU_SRA  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    typedef enum logic [2:0] {
        ST_RST    = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        CL_R      = 3'd0,
        CL_IALU   = 3'd1,
        CL_LOAD   = 3'd2,
        CL_STORE  = 3'd3,
        CL_BRANCH = 3'd4,
        CL_JAL    = 3'd5,
        CL_LUI    = 3'd6,
        CL_BAD    = 3'd7
    } class_t;

    localparam logic [1:0] SRCA_PC    = 2'd0;
    localparam logic [1:0] SRCA_OLDPC = 2'd1;
    localparam logic [1:0] SRCA_RS1   = 2'd2;
    localparam logic [1:0] SRCA_ZERO  = 2'd3;

    localparam logic [1:0] SRCB_RS2   = 2'd0;
    localparam logic [1:0] SRCB_IMM   = 2'd1;
    localparam logic [1:0] SRCB_FOUR  = 2'd2;

    localparam logic [1:0] RES_ALU    = 2'd0;
    localparam logic [1:0] RES_MEM    = 2'd1;
    localparam logic [1:0] RES_PC4    = 2'd2;

    // Opcode-only classification; funct-field legality is left to alu_decoder.
    function automatic class_t opcode_class(input logic [6:0] opcode, input logic en_branch);
        class_t c;
        case (opcode)
            OPC_R:      c = CL_R;
            OPC_IALU:   c = CL_IALU;
            OPC_LOAD:   c = CL_LOAD;
            OPC_STORE:  c = CL_STORE;
            OPC_BRANCH: c = en_branch ? CL_BRANCH : CL_BAD;
            OPC_JAL:    c = en_branch ? CL_JAL : CL_BAD;
            OPC_LUI:    c = CL_LUI;
            default:    c = CL_BAD;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU opcode decode from instruction class and funct fields,
// flagging funct encodings that are illegal for the configured ALU width.
module alu_decoder
    import rv32_ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W = 4
) (
    input  logic [2:0] i_class,
    input  logic [2:0] i_funct3,
    input  logic [6:0] i_funct7,
    output logic [3:0] o_alu_code,
    output logic       o_illegal
);

    logic w_uses_funct7;

    always_comb begin
        o_alu_code    = ALU_ADD;
        o_illegal     = 1'b0;
        w_uses_funct7 = 1'b0;
        case (i_class)
            CL_R, CL_IALU: begin
                case (i_funct3)
                    3'b000:  o_alu_code = ((i_class == CL_R) && i_funct7[5]) ? ALU_SUB : ALU_ADD;
                    3'b001:  o_alu_code = ALU_SLL;
                    3'b010:  o_alu_code = ALU_SLT;
                    3'b011:  o_alu_code = ALU_SLTU;
                    3'b100:  o_alu_code = ALU_XOR;
                    3'b101:  o_alu_code = i_funct7[5] ? ALU_SRA : ALU_SRL;
                    3'b110:  o_alu_code = ALU_OR;
                    default: o_alu_code = ALU_AND;
                endcase
                // I-type only carries funct7 in the shift-immediate forms.
                w_uses_funct7 = (i_class == CL_R) || (i_funct3 == 3'b001) || (i_funct3 == 3'b101);
                if (w_uses_funct7 && (i_funct7 != 7'b0000000) && (i_funct7 != 7'b0100000)) begin
                    o_illegal = 1'b1;
                end
                if ((ALU_CTRL_W < 4) && ((o_alu_code == ALU_SRA) || (o_alu_code == ALU_SLTU))) begin
                    o_illegal = 1'b1;
                end
            end
            CL_BRANCH: begin
                o_alu_code = ALU_SUB;
                o_illegal  = (i_funct3[2:1] != 2'b00);
            end
            CL_BAD: begin
                o_illegal = 1'b1;
            end
            default: begin
                o_alu_code = ALU_ADD;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle control FSM for the RV32 core: FETCH/DECODE/EXEC/MEM/WB sequencing,
// datapath mux and write-enable control, memory req/ready handshake, illegal trap.
module multicycle_control
    import rv32_ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W = 4,
    parameter bit EN_BRANCH  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           instr,
    input  logic                  mem_ready,
    input  logic                  alu_zero,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic                  ir_write,
    output logic                  pc_write,
    output logic                  oldpc_write,
    output logic                  reg_write,
    output logic [1:0]            alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [1:0]            result_src,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic                  illegal,
    output logic [2:0]            state
);

    state_t     r_state;
    state_t     w_next;
    class_t     r_class;
    logic       r_started;

    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    class_t     w_raw_class;
    class_t     w_dec_class;
    logic [3:0] w_alu_code;
    logic       w_alu_illegal;
    logic [3:0] w_alu_sel;
    logic       w_unused_instr;

    assign w_funct3       = instr[14:12];
    assign w_funct7       = instr[31:25];
    assign w_raw_class    = opcode_class(instr[6:0], EN_BRANCH);
    assign w_dec_class    = w_alu_illegal ? CL_BAD : w_raw_class;
    assign w_unused_instr = ^{instr[24:15], instr[11:7]};

    alu_decoder #(
        .ALU_CTRL_W(ALU_CTRL_W)
    ) u_alu_decoder (
        .i_class    (w_raw_class),
        .i_funct3   (w_funct3),
        .i_funct7   (w_funct7),
        .o_alu_code (w_alu_code),
        .o_illegal  (w_alu_illegal)
    );

    // r_started holds RST for one extra cycle so FETCH starts two cycles after release.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_RST;
            r_class   <= CL_R;
            r_started <= 1'b0;
        end else begin
            r_started <= 1'b1;
            r_state   <= w_next;
            if (r_state == ST_DECODE) begin
                r_class <= w_dec_class;
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        oldpc_write = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = SRCA_PC;
        alu_src_b   = SRCB_RS2;
        result_src  = RES_ALU;
        w_alu_sel   = ALU_ADD;
        illegal     = 1'b0;
        case (r_state)
            ST_RST: begin
                w_next = r_started ? ST_FETCH : ST_RST;
            end
            ST_FETCH: begin
                mem_req   = 1'b1;
                alu_src_a = SRCA_PC;
                alu_src_b = SRCB_FOUR;
                w_alu_sel = ALU_ADD;
                if (mem_ready) begin
                    ir_write    = 1'b1;
                    pc_write    = 1'b1;
                    oldpc_write = 1'b1;
                    w_next      = ST_DECODE;
                end
            end
            ST_DECODE: begin
                w_next = (w_dec_class == CL_BAD) ? ST_TRAP : ST_EXEC;
            end
            ST_EXEC: begin
                w_alu_sel = w_alu_code;
                case (r_class)
                    CL_R: begin
                        alu_src_a = SRCA_RS1;
                        alu_src_b = SRCB_RS2;
                        w_next    = ST_WB;
                    end
                    CL_IALU: begin
                        alu_src_a = SRCA_RS1;
                        alu_src_b = SRCB_IMM;
                        w_next    = ST_WB;
                    end
                    CL_LOAD, CL_STORE: begin
                        alu_src_a = SRCA_RS1;
                        alu_src_b = SRCB_IMM;
                        w_next    = ST_MEM;
                    end
                    CL_LUI: begin
                        alu_src_a = SRCA_ZERO;
                        alu_src_b = SRCB_IMM;
                        w_next    = ST_WB;
                    end
                    CL_BRANCH: begin
                        alu_src_a = SRCA_RS1;
                        alu_src_b = SRCB_RS2;
                        pc_write  = ((w_funct3 == 3'b000) && alu_zero) ||
                                    ((w_funct3 == 3'b001) && !alu_zero);
                        w_next    = ST_FETCH;
                    end
                    CL_JAL: begin
                        alu_src_a = SRCA_OLDPC;
                        alu_src_b = SRCB_IMM;
                        pc_write  = 1'b1;
                        w_next    = ST_WB;
                    end
                    default: begin
                        w_next = ST_TRAP;
                    end
                endcase
            end
            ST_MEM: begin
                mem_req = 1'b1;
                mem_we  = (r_class == CL_STORE);
                if (mem_ready) begin
                    w_next = (r_class == CL_LOAD) ? ST_WB : ST_FETCH;
                end
            end
            ST_WB: begin
                reg_write = 1'b1;
                if (r_class == CL_LOAD) begin
                    result_src = RES_MEM;
                end else if (r_class == CL_JAL) begin
                    result_src = RES_PC4;
                end else begin
                    result_src = RES_ALU;
                end
                w_next = ST_FETCH;
            end
            ST_TRAP: begin
                illegal = 1'b1;
            end
            default: begin
                w_next = ST_RST;
            end
        endcase
    end

    assign alu_control = w_alu_sel[ALU_CTRL_W-1:0];
    assign state       = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: a per-instruction reference model expands
// each instruction into its expected cycle trace, which is compared cycle by cycle.
module tb_multicycle_control;

    localparam logic [2:0] S_RST = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3;
    localparam logic [2:0] S_MEM = 3'd4, S_WB = 3'd5, S_TRAP = 3'd6;
    localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BR = 4, K_JAL = 5, K_LUI = 6, K_BAD = 7;
    localparam logic [3:0] ALU_TAB [8] = '{4'd0, 4'd4, 4'd5, 4'd9, 4'd6, 4'd7, 4'd3, 4'd2};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = '0;
    logic        mem_ready = 1'b0;
    logic        alu_zero = 1'b0;

    logic       m4_req, m4_we, m4_irw, m4_pcw, m4_opcw, m4_rw, m4_ill;
    logic [1:0] m4_a, m4_b, m4_rs;
    logic [3:0] m4_alu;
    logic [2:0] m4_st;
    logic       m3_req, m3_we, m3_irw, m3_pcw, m3_opcw, m3_rw, m3_ill;
    logic [1:0] m3_a, m3_b, m3_rs;
    logic [2:0] m3_alu;
    logic [2:0] m3_st;

    multicycle_control #(.ALU_CTRL_W(4), .EN_BRANCH(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ready(mem_ready), .alu_zero(alu_zero),
        .mem_req(m4_req), .mem_we(m4_we), .ir_write(m4_irw), .pc_write(m4_pcw),
        .oldpc_write(m4_opcw), .reg_write(m4_rw), .alu_src_a(m4_a), .alu_src_b(m4_b),
        .result_src(m4_rs), .alu_control(m4_alu), .illegal(m4_ill), .state(m4_st)
    );

    multicycle_control #(.ALU_CTRL_W(3), .EN_BRANCH(1'b1)) dut3 (
        .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ready(mem_ready), .alu_zero(alu_zero),
        .mem_req(m3_req), .mem_we(m3_we), .ir_write(m3_irw), .pc_write(m3_pcw),
        .oldpc_write(m3_opcw), .reg_write(m3_rw), .alu_src_a(m3_a), .alu_src_b(m3_b),
        .result_src(m3_rs), .alu_control(m3_alu), .illegal(m3_ill), .state(m3_st)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ins;
        logic        rdy;
        logic        zero;
        logic [2:0]  st;
        logic [16:0] outv;
    } cyc_t;

    cyc_t exp_q[$];
    int   passed = 0;
    int   total = 0;
    bit   sel3 = 1'b0;

    logic [2:0]  obs_st;
    logic [16:0] obs_out;

    always_comb begin
        if (sel3) begin
            obs_st  = m3_st;
            obs_out = {m3_req, m3_we, m3_irw, m3_pcw, m3_opcw, m3_rw, m3_ill,
                       m3_a, m3_b, m3_rs, 1'b0, m3_alu};
        end else begin
            obs_st  = m4_st;
            obs_out = {m4_req, m4_we, m4_irw, m4_pcw, m4_opcw, m4_rw, m4_ill,
                       m4_a, m4_b, m4_rs, m4_alu};
        end
    end

    function automatic logic rb();
        return 1'($urandom & 32'd1);
    endfunction

    function automatic logic [16:0] pk(input logic req, we, irw, pcw, opcw, rw, ill,
                                       input logic [1:0] a, b, rs, input logic [3:0] alu);
        return {req, we, irw, pcw, opcw, rw, ill, a, b, rs, alu};
    endfunction

    // Reference decode straight from the ISA tables: class, ALU op and legality.
    function automatic void ref_decode(input logic [31:0] ins, input int w,
                                       output int kind, output logic [3:0] alu);
        logic [6:0] opc;
        logic [6:0] f7;
        logic [2:0] f3;
        opc  = ins[6:0];
        f3   = ins[14:12];
        f7   = ins[31:25];
        alu  = 4'd0;
        kind = K_BAD;
        case (opc)
            7'h33, 7'h13: begin
                kind = (opc == 7'h33) ? K_R : K_I;
                alu  = ALU_TAB[f3];
                if (f3 == 3'd0 && kind == K_R && f7[5]) alu = 4'd1;
                if (f3 == 3'd5 && f7[5]) alu = 4'd8;
                if ((kind == K_R || f3 == 3'd1 || f3 == 3'd5) && !(f7 == 7'h00 || f7 == 7'h20)) kind = K_BAD;
                if (w == 3 && alu >= 4'd8) kind = K_BAD;
            end
            7'h03: kind = K_LD;
            7'h23: kind = K_ST;
            7'h63: begin
                kind = (f3 <= 3'd1) ? K_BR : K_BAD;
                alu  = 4'd1;
            end
            7'h6F: kind = K_JAL;
            7'h37: kind = K_LUI;
            default: kind = K_BAD;
        endcase
    endfunction

    task automatic push(input logic [31:0] ins, input logic rdy, input logic zero,
                        input logic [2:0] st, input logic [16:0] outv);
        cyc_t e;
        e.ins = ins; e.rdy = rdy; e.zero = zero; e.st = st; e.outv = outv;
        exp_q.push_back(e);
    endtask

    task automatic build(input logic [31:0] ins, input int fw, input int mw,
                         input logic zero, output bit trapped);
        int         kind;
        logic [3:0] alu;
        logic [1:0] a, b, rs;
        logic       pcw;
        ref_decode(ins, sel3 ? 3 : 4, kind, alu);
        trapped = 1'b0;
        for (int i = 0; i < fw; i++)
            push(ins, 1'b0, rb(), S_FETCH, pk(1, 0, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd0, 4'd0));
        push(ins, 1'b1, rb(), S_FETCH, pk(1, 0, 1, 1, 1, 0, 0, 2'd0, 2'd2, 2'd0, 4'd0));
        push(ins, rb(), rb(), S_DECODE, '0);
        if (kind == K_BAD) begin
            for (int i = 0; i < 3; i++)
                push(ins, rb(), rb(), S_TRAP, pk(0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, 4'd0));
            trapped = 1'b1;
            return;
        end
        pcw = 1'b0;
        a   = 2'd2;
        b   = 2'd1;
        case (kind)
            K_R:   b = 2'd0;
            K_LUI: a = 2'd3;
            K_JAL: begin a = 2'd1; pcw = 1'b1; end
            K_BR:  begin b = 2'd0; pcw = (ins[14:12] == 3'd0) ? zero : !zero; end
            default: ;
        endcase
        push(ins, rb(), (kind == K_BR) ? zero : rb(), S_EXEC, pk(0, 0, 0, pcw, 0, 0, 0, a, b, 2'd0, alu));
        if (kind == K_BR) return;
        if (kind == K_LD || kind == K_ST) begin
            for (int i = 0; i < mw; i++)
                push(ins, 1'b0, rb(), S_MEM, pk(1, kind == K_ST, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 4'd0));
            push(ins, 1'b1, rb(), S_MEM, pk(1, kind == K_ST, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 4'd0));
            if (kind == K_ST) return;
        end
        rs = (kind == K_LD) ? 2'd1 : (kind == K_JAL) ? 2'd2 : 2'd0;
        push(ins, rb(), rb(), S_WB, pk(0, 0, 0, 0, 0, 1, 0, 2'd0, 2'd0, rs, 4'd0));
    endtask

    // Plays up to n expected cycles (all if n < 0); entered and left at posedge+1.
    task automatic run(input string name, input int n);
        cyc_t e;
        int   k;
        k = 0;
        while (exp_q.size() > 0 && (n < 0 || k < n)) begin
            e = exp_q.pop_front();
            instr     = e.ins;
            mem_ready = e.rdy;
            alu_zero  = e.zero;
            @(negedge clk);
            total++;
            if (obs_st !== e.st)
                $display("FAIL %s cyc%0d state: got %0d want %0d", name, k, obs_st, e.st);
            else
                passed++;
            total++;
            if (obs_out !== e.outv)
                $display("FAIL %s cyc%0d outputs: got %05h want %05h", name, k, obs_out, e.outv);
            else
                passed++;
            @(posedge clk);
            #1;
            k++;
        end
    endtask

    task automatic do_reset(input string name);
        rst_n     = 1'b0;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (obs_st !== S_RST)
            $display("FAIL %s reset_state: got %0d want %0d", name, obs_st, S_RST);
        else
            passed++;
        total++;
        if (obs_out !== 17'h0)
            $display("FAIL %s reset_outputs: got %05h want 00000", name, obs_out);
        else
            passed++;
        @(posedge clk);
        #1;
        push(instr, rb(), rb(), S_RST, '0);
    endtask

    task automatic test_reset();
        do_reset("reset");
        run("reset", -1);
    endtask

    task automatic test_add();
        bit t;
        build(32'h002081B3, 0, 0, 1'b0, t);
        build(32'h002081B3, 1, 0, 1'b0, t);
        run("add", -1);
    endtask

    task automatic test_load_wait();
        bit t;
        build(32'h0040A183, 0, 3, 1'b0, t);
        run("lw_wait", -1);
    endtask

    task automatic test_back_to_back_branch();
        bit t;
        build(32'h00208463, 0, 0, 1'b1, t);
        build(32'h00208463, 0, 0, 1'b0, t);
        build(32'h00209463, 0, 0, 1'b0, t);
        build(32'h00209463, 0, 0, 1'b1, t);
        run("branch", -1);
    endtask

    task automatic test_srai_width();
        bit t;
        do_reset("srai4");
        build(32'h4030D193, 0, 0, 1'b0, t);
        run("srai4", -1);
        sel3 = 1'b1;
        do_reset("srai3");
        build(32'h4030D193, 0, 0, 1'b0, t);
        run("srai3", -1);
        sel3 = 1'b0;
    endtask

    task automatic test_trap_and_reset();
        bit t;
        do_reset("trap");
        build(32'h0000007F, 0, 0, 1'b0, t);
        run("trap", -1);
        do_reset("trap_clear");
        build(32'h0020A223, 0, 5, 1'b0, t);
        run("sw_abort", 5);
        exp_q.delete();
        do_reset("sw_abort");
        build(32'h002081B3, 0, 0, 1'b0, t);
        run("after_abort", -1);
    endtask

    task automatic test_random(input bit w3, input int count);
        logic [31:0] ins;
        int          r;
        bit          t;
        sel3 = w3;
        do_reset("random");
        for (int n = 0; n < count; n++) begin
            ins = $urandom;
            r   = $urandom_range(0, 15);
            if (r <= 2 || r >= 13) ins[6:0] = 7'h33;
            else if (r <= 5)       ins[6:0] = 7'h13;
            else if (r == 6)       ins[6:0] = 7'h03;
            else if (r == 7)       ins[6:0] = 7'h23;
            else if (r <= 9)       ins[6:0] = 7'h63;
            else if (r == 10)      ins[6:0] = 7'h6F;
            else if (r == 11)      ins[6:0] = 7'h37;
            if ((ins[6:0] == 7'h33 || ins[6:0] == 7'h13) && $urandom_range(0, 3) != 0)
                ins[31:25] = rb() ? 7'h20 : 7'h00;
            if (ins[6:0] == 7'h63 && $urandom_range(0, 3) != 0)
                ins[14:12] = {2'b00, rb()};
            build(ins, $urandom_range(0, 2), $urandom_range(0, 2), rb(), t);
            run("random", -1);
            if (t) do_reset("random");
        end
        run("random", -1);
        sel3 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_add();
        test_load_wait();
        test_back_to_back_branch();
        test_srai_width();
        test_trap_and_reset();
        test_random(1'b0, 60);
        test_random(1'b1, 25);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1);
    end

endmodule
